// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// The address splits into tag | idx | word offset | byte offset; all widths derive from the set count and line size.
package dcache_pkg;

    localparam int DCACHE_SETS      = 16;
    localparam int DCACHE_LINE_BITS = 256;

    localparam int WORD_BITS     = 32;
    localparam int WORDS         = DCACHE_LINE_BITS / WORD_BITS;
    localparam int LINE_BYTES    = DCACHE_LINE_BITS / 8;
    localparam int BYTE_OFF_BITS = 2;
    localparam int OFF_BITS      = $clog2(WORDS);
    localparam int LINE_OFF_BITS = OFF_BITS + BYTE_OFF_BITS;
    localparam int IDX_BITS      = $clog2(DCACHE_SETS);
    localparam int TAG_BITS      = 32 - IDX_BITS - LINE_OFF_BITS;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        WB,
        FILL
    } dcache_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } dcache_req_t;

    // Rebuild a line-aligned memory address from a tag and a set index.
    function automatic logic [31:0] line_addr(input logic [TAG_BITS-1:0] tag,
                                              input logic [IDX_BITS-1:0] idx);
        return {tag, idx, {LINE_OFF_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Storage for the data cache: line data with per-byte write enables, plus tag, valid and dirty per set.
// A single index serves both the asynchronous read and the synchronous write.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IDX_BITS-1:0]         idx,
    output logic [DCACHE_LINE_BITS-1:0] line_data,
    output logic [TAG_BITS-1:0]         line_tag,
    output logic                        line_valid,
    output logic                        line_dirty,
    input  logic [LINE_BYTES-1:0]       byte_we,
    input  logic [DCACHE_LINE_BITS-1:0] wdata,
    input  logic                        tag_we,
    input  logic [TAG_BITS-1:0]         tag_in,
    input  logic                        set_valid,
    input  logic                        set_dirty,
    input  logic                        clr_dirty
);

    logic [DCACHE_LINE_BITS-1:0] data_arr [DCACHE_SETS];
    logic [TAG_BITS-1:0]         tag_arr  [DCACHE_SETS];
    logic [DCACHE_SETS-1:0]      valid_arr;
    logic [DCACHE_SETS-1:0]      dirty_arr;

    // Byte-granular line write; a fill enables all bytes, a store hit only its lanes.
    always_ff @(posedge clk) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (byte_we[b]) begin
                data_arr[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Tag update happens only when a new line is installed.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_arr[idx] <= tag_in;
        end
    end

    // Valid and dirty are the only array state cleared by reset, which is enough to invalidate the cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_arr <= '0;
            dirty_arr <= '0;
        end else begin
            if (set_valid) begin
                valid_arr[idx] <= 1'b1;
            end
            if (clr_dirty) begin
                dirty_arr[idx] <= 1'b0;
            end else if (set_dirty) begin
                dirty_arr[idx] <= 1'b1;
            end
        end
    end

    assign line_data  = data_arr[idx];
    assign line_tag   = tag_arr[idx];
    assign line_valid = valid_arr[idx];
    assign line_dirty = dirty_arr[idx];

endmodule

// File: rtl/dcache.sv
// Blocking, direct-mapped, write-back data cache serving single-word LSQ requests.
// One request is held at a time; misses write back a dirty victim, fill the line, then re-compare and hit.
module dcache
    import dcache_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 dmem_addr,
    input  logic [3:0]                  dmem_rmask,
    input  logic [3:0]                  dmem_wmask,
    input  logic [31:0]                 dmem_wdata,
    output logic [31:0]                 dmem_rdata,
    output logic                        dmem_resp,
    output logic [31:0]                 mem_addr,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [DCACHE_LINE_BITS-1:0] mem_wdata,
    input  logic [DCACHE_LINE_BITS-1:0] mem_rdata,
    input  logic                        mem_resp
);

    dcache_state_t state;
    dcache_req_t   req;
    logic          is_store;

    logic [TAG_BITS-1:0] req_tag;
    logic [IDX_BITS-1:0] req_idx;
    logic [OFF_BITS-1:0] req_off;

    logic [DCACHE_LINE_BITS-1:0] line_data;
    logic [TAG_BITS-1:0]         line_tag;
    logic                        line_valid;
    logic                        line_dirty;

    logic [LINE_BYTES-1:0]       byte_we;
    logic [DCACHE_LINE_BITS-1:0] arr_wdata;
    logic                        tag_we;
    logic                        set_valid;
    logic                        set_dirty;
    logic                        clr_dirty;

    logic        hit;
    logic        cmp_hit;
    logic        store_hit;
    logic        fill_done;
    logic        new_req;
    logic [31:0] word;
    logic        unused_bits;

    assign req_tag = req.addr[31 -: TAG_BITS];
    assign req_idx = req.addr[LINE_OFF_BITS +: IDX_BITS];
    assign req_off = req.addr[BYTE_OFF_BITS +: OFF_BITS];

    // Load width is decided by the LSQ from the full word, so rmask content and byte offset are not needed here.
    assign unused_bits = ^{req.rmask, req.addr[1:0]};

    dcache_array u_array (
        .clk        (clk),
        .rst        (rst),
        .idx        (req_idx),
        .line_data  (line_data),
        .line_tag   (line_tag),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .byte_we    (byte_we),
        .wdata      (arr_wdata),
        .tag_we     (tag_we),
        .tag_in     (req_tag),
        .set_valid  (set_valid),
        .set_dirty  (set_dirty),
        .clr_dirty  (clr_dirty)
    );

    assign new_req   = (|dmem_rmask) || (|dmem_wmask);
    assign hit       = line_valid && (line_tag == req_tag);
    assign cmp_hit   = (state == CMP) && hit;
    assign store_hit = cmp_hit && is_store;
    assign fill_done = (state == FILL) && mem_resp;
    assign word      = line_data[WORD_BITS*req_off +: WORD_BITS];

    // The response is the compare-cycle hit itself, which is what gives a one-cycle hit latency.
    assign dmem_resp  = cmp_hit;
    assign dmem_rdata = cmp_hit ? word : '0;

    // Array write controls: a completed fill installs the whole line clean; a store hit merges its lanes and dirties the set.
    always_comb begin
        byte_we   = '0;
        arr_wdata = {WORDS{req.wdata}};
        tag_we    = 1'b0;
        set_valid = 1'b0;
        set_dirty = 1'b0;
        clr_dirty = 1'b0;
        if (fill_done) begin
            byte_we   = '1;
            arr_wdata = mem_rdata;
            tag_we    = 1'b1;
            set_valid = 1'b1;
            clr_dirty = 1'b1;
        end else if (store_hit) begin
            byte_we[4*req_off +: 4] = req.wmask;
            set_dirty               = 1'b1;
        end
    end

    // Controller FSM with registered memory-side outputs, held steady until mem_resp.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req       <= '0;
            is_store  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_req) begin
                        req.addr  <= dmem_addr;
                        req.rmask <= dmem_rmask;
                        req.wmask <= dmem_wmask;
                        req.wdata <= dmem_wdata;
                        is_store  <= |dmem_wmask;
                        state     <= CMP;
                    end
                end
                CMP: begin
                    if (hit) begin
                        state <= IDLE;
                    end else if (line_valid && line_dirty) begin
                        mem_write <= 1'b1;
                        mem_addr  <= line_addr(line_tag, req_idx);
                        mem_wdata <= line_data;
                        state     <= WB;
                    end else begin
                        mem_read <= 1'b1;
                        mem_addr <= line_addr(req_tag, req_idx);
                        state    <= FILL;
                    end
                end
                WB: begin
                    if (mem_resp) begin
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= line_addr(req_tag, req_idx);
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (mem_resp) begin
                        mem_read <= 1'b0;
                        state    <= CMP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_no_dual_mask: assert property (@(posedge clk) disable iff (rst)
        !((|dmem_rmask) && (|dmem_wmask)));

    a_req_only_idle: assert property (@(posedge clk) disable iff (rst)
        (state != IDLE) |-> !new_req);

    a_mem_exclusive: assert property (@(posedge clk)
        !(mem_read && mem_write));

endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache: cold miss, hit, store merge, dirty eviction, reset mid-fill, back-to-back hits.
module tb_dcache;

    localparam int MEM_LAT = 3;

    logic         clk;
    logic         rst;
    logic [31:0]  dmem_addr;
    logic [3:0]   dmem_rmask;
    logic [3:0]   dmem_wmask;
    logic [31:0]  dmem_wdata;
    logic [31:0]  dmem_rdata;
    logic         dmem_resp;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    int n_vec;
    int n_miss;
    int resp_total;

    logic [255:0] line_a;
    logic [255:0] line_a_dirty;
    logic [255:0] line_b;

    dcache dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running count of response cycles, sampled away from the active edge.
    initial resp_total = 0;
    always @(negedge clk) begin
        if (dmem_resp === 1'b1) resp_total = resp_total + 1;
    end

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    // One-cycle request pulse: drive at a negedge, drop at the next one (the compare cycle).
    task automatic issue(input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        dmem_addr  = a;
        dmem_rmask = rm;
        dmem_wmask = wm;
        dmem_wdata = wd;
        @(negedge clk);
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        dmem_wdata = 32'h0;
    endtask

    task automatic wait_resp(output int cycles, output logic [31:0] data, output bit seen_mem, output bit ok);
        cycles = 0; data = '0; seen_mem = 0; ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (mem_read || mem_write) seen_mem = 1;
            if (dmem_resp === 1'b1) begin
                data = dmem_rdata;
                ok = 1;
                return;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic wait_mem(output bit rd, output bit wr, output logic [31:0] a, output logic [255:0] wd, output bit ok);
        rd = 0; wr = 0; a = '0; wd = '0; ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (mem_read === 1'b1 || mem_write === 1'b1) begin
                rd = mem_read; wr = mem_write; a = mem_addr; wd = mem_wdata;
                ok = 1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic mem_reply(input logic [255:0] data);
        repeat (MEM_LAT) @(negedge clk);
        mem_rdata = data;
        mem_resp  = 1'b1;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (dmem_resp !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_resp: got %b expected 0", dmem_resp); end
        n_vec++; if (mem_read !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_mem_read: got %b expected 0", mem_read); end
        n_vec++; if (mem_write !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_mem_write: got %b expected 0", mem_write); end
        n_vec++; if (mem_addr !== 32'h0) begin n_miss++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        n_vec++; if (dmem_rdata !== 32'h0) begin n_miss++; $display("[TB] FAIL reset_rdata: got %h expected 0", dmem_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_cold_load();
        bit rd, wr, ok, seen; logic [31:0] a, d; logic [255:0] wd; int cyc;
        issue(4'hF, 4'h0, 32'h0000_1004, 32'h0);
        wait_mem(rd, wr, a, wd, ok);
        n_vec++; if (!ok) begin n_miss++; $display("[TB] FAIL cold_mem_timeout: got none expected mem request"); end
        n_vec++; if ({rd, wr} !== 2'b10) begin n_miss++; $display("[TB] FAIL cold_op: got rd/wr %b expected 10", {rd, wr}); end
        n_vec++; if (a !== 32'h0000_1000) begin n_miss++; $display("[TB] FAIL cold_addr: got %h expected 00001000", a); end
        mem_reply(line_a);
        wait_resp(cyc, d, seen, ok);
        n_vec++; if (!ok) begin n_miss++; $display("[TB] FAIL cold_resp_timeout: got none expected resp"); end
        n_vec++; if (cyc !== 0) begin n_miss++; $display("[TB] FAIL cold_resp_lat: got %0d expected 0 cycles after fill", cyc); end
        n_vec++; if (d !== 32'hDEAD_BEEF) begin n_miss++; $display("[TB] FAIL cold_rdata: got %h expected deadbeef", d); end
    endtask

    task automatic test_hit();
        bit ok, seen; logic [31:0] d; int cyc;
        issue(4'hF, 4'h0, 32'h0000_1004, 32'h0);
        wait_resp(cyc, d, seen, ok);
        n_vec++; if (!ok) begin n_miss++; $display("[TB] FAIL hit_timeout: got none expected resp"); end
        n_vec++; if (cyc !== 0) begin n_miss++; $display("[TB] FAIL hit_lat: got %0d expected 0", cyc); end
        n_vec++; if (seen !== 1'b0) begin n_miss++; $display("[TB] FAIL hit_mem_access: got %b expected 0", seen); end
        n_vec++; if (d !== 32'hDEAD_BEEF) begin n_miss++; $display("[TB] FAIL hit_rdata: got %h expected deadbeef", d); end
    endtask

    task automatic test_store_merge();
        bit ok, seen; logic [31:0] d; int cyc;
        issue(4'h0, 4'b0100, 32'h0000_1004, 32'h00AB_0000);
        wait_resp(cyc, d, seen, ok);
        n_vec++; if (!ok || cyc !== 0) begin n_miss++; $display("[TB] FAIL store_hit_lat: got ok=%b cyc=%0d expected ok=1 cyc=0", ok, cyc); end
        n_vec++; if (seen !== 1'b0) begin n_miss++; $display("[TB] FAIL store_mem_access: got %b expected 0", seen); end
        issue(4'hF, 4'h0, 32'h0000_1004, 32'h0);
        wait_resp(cyc, d, seen, ok);
        n_vec++; if (!ok || cyc !== 0) begin n_miss++; $display("[TB] FAIL merge_load_lat: got ok=%b cyc=%0d expected ok=1 cyc=0", ok, cyc); end
        n_vec++; if (d !== 32'hDEAB_BEEF) begin n_miss++; $display("[TB] FAIL merge_rdata: got %h expected deabbeef", d); end
    endtask

    task automatic test_dirty_evict();
        bit rd, wr, ok, seen; logic [31:0] a, d; logic [255:0] wd; int cyc;
        issue(4'hF, 4'h0, 32'h0000_1204, 32'h0);
        wait_mem(rd, wr, a, wd, ok);
        n_vec++; if (!ok || {rd, wr} !== 2'b01) begin n_miss++; $display("[TB] FAIL evict_wb_op: got ok=%b rd/wr=%b expected ok=1 rd/wr=01", ok, {rd, wr}); end
        n_vec++; if (a !== 32'h0000_1000) begin n_miss++; $display("[TB] FAIL evict_wb_addr: got %h expected 00001000", a); end
        n_vec++; if (wd[63:32] !== 32'hDEAB_BEEF) begin n_miss++; $display("[TB] FAIL evict_wb_word1: got %h expected deabbeef", wd[63:32]); end
        n_vec++; if (wd !== line_a_dirty) begin n_miss++; $display("[TB] FAIL evict_wb_line: got %h expected %h", wd, line_a_dirty); end
        mem_reply('0);
        wait_mem(rd, wr, a, wd, ok);
        n_vec++; if (!ok || {rd, wr} !== 2'b10) begin n_miss++; $display("[TB] FAIL evict_fill_op: got ok=%b rd/wr=%b expected ok=1 rd/wr=10", ok, {rd, wr}); end
        n_vec++; if (a !== 32'h0000_1200) begin n_miss++; $display("[TB] FAIL evict_fill_addr: got %h expected 00001200", a); end
        mem_reply(line_b);
        wait_resp(cyc, d, seen, ok);
        n_vec++; if (!ok || cyc !== 0) begin n_miss++; $display("[TB] FAIL evict_resp: got ok=%b cyc=%0d expected ok=1 cyc=0", ok, cyc); end
        n_vec++; if (d !== 32'hB0B0_0001) begin n_miss++; $display("[TB] FAIL evict_rdata: got %h expected b0b00001", d); end
    endtask

    task automatic test_reset_mid_fill();
        bit rd, wr, ok, seen; logic [31:0] a, d; logic [255:0] wd; int cyc;
        issue(4'hF, 4'h0, 32'h0000_2008, 32'h0);
        wait_mem(rd, wr, a, wd, ok);
        n_vec++; if (!ok || {rd, wr} !== 2'b10 || a !== 32'h0000_2000) begin n_miss++; $display("[TB] FAIL midfill_req: got ok=%b rd/wr=%b addr=%h expected ok=1 rd/wr=10 addr=00002000", ok, {rd, wr}, a); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (mem_read !== 1'b0) begin n_miss++; $display("[TB] FAIL midfill_mem_read: got %b expected 0", mem_read); end
        n_vec++; if (dmem_resp !== 1'b0) begin n_miss++; $display("[TB] FAIL midfill_resp: got %b expected 0", dmem_resp); end
        n_vec++; if (mem_addr !== 32'h0) begin n_miss++; $display("[TB] FAIL midfill_mem_addr: got %h expected 0", mem_addr); end
        rst = 1'b0;
        mem_rdata = line_b;
        mem_resp  = 1'b1;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = '0;
        n_vec++; if (dmem_resp !== 1'b0 || mem_read !== 1'b0) begin n_miss++; $display("[TB] FAIL late_mem_resp: got resp=%b mem_read=%b expected 0 0", dmem_resp, mem_read); end
        issue(4'hF, 4'h0, 32'h0000_1204, 32'h0);
        wait_mem(rd, wr, a, wd, ok);
        n_vec++; if (!ok || {rd, wr} !== 2'b10 || a !== 32'h0000_1200) begin n_miss++; $display("[TB] FAIL post_reset_miss: got ok=%b rd/wr=%b addr=%h expected ok=1 rd/wr=10 addr=00001200", ok, {rd, wr}, a); end
        mem_reply(line_b);
        wait_resp(cyc, d, seen, ok);
        n_vec++; if (!ok || d !== 32'hB0B0_0001) begin n_miss++; $display("[TB] FAIL post_reset_rdata: got ok=%b %h expected ok=1 b0b00001", ok, d); end
    endtask

    typedef struct {
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    task automatic test_back_to_back();
        vec_t v[8];
        bit ok, seen; logic [31:0] d; int cyc; int start_cnt;
        v[0] = '{4'h0, 4'hF,    32'h0000_1200, 32'h1122_3344, 32'h0};
        v[1] = '{4'hF, 4'h0,    32'h0000_1200, 32'h0,         32'h1122_3344};
        v[2] = '{4'h0, 4'b0001, 32'h0000_120C, 32'h0000_00AA, 32'h0};
        v[3] = '{4'hF, 4'h0,    32'h0000_120C, 32'h0,         32'hB0B0_00AA};
        v[4] = '{4'h0, 4'b1000, 32'h0000_1214, 32'h7700_0000, 32'h0};
        v[5] = '{4'hF, 4'h0,    32'h0000_1214, 32'h0,         32'h77B0_0005};
        v[6] = '{4'h0, 4'b0110, 32'h0000_121C, 32'h00CD_EF00, 32'h0};
        v[7] = '{4'hF, 4'h0,    32'h0000_121C, 32'h0,         32'hB0CD_EF07};
        @(negedge clk);
        start_cnt = resp_total;
        for (int i = 0; i < 8; i++) begin
            issue(v[i].rm, v[i].wm, v[i].addr, v[i].wdata);
            wait_resp(cyc, d, seen, ok);
            n_vec++; if (!ok || cyc !== 0 || seen !== 1'b0) begin n_miss++; $display("[TB] FAIL b2b_hit_%0d: got ok=%b cyc=%0d mem=%b expected ok=1 cyc=0 mem=0", i, ok, cyc, seen); end
            if (v[i].rm != 4'h0) begin
                n_vec++; if (d !== v[i].exp) begin n_miss++; $display("[TB] FAIL b2b_rdata_%0d: got %h expected %h", i, d, v[i].exp); end
            end
        end
        @(negedge clk);
        n_vec++; if (resp_total - start_cnt !== 8) begin n_miss++; $display("[TB] FAIL b2b_resp_count: got %0d expected 8", resp_total - start_cnt); end
    endtask

    // Test sequence.
    initial begin
        n_vec = 0;
        n_miss = 0;
        rst = 1'b1;
        dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        line_a = make_line(32'h1111_0000);
        line_a[63:32] = 32'hDEAD_BEEF;
        line_a_dirty = line_a;
        line_a_dirty[63:32] = 32'hDEAB_BEEF;
        line_b = make_line(32'hB0B0_0000);

        test_reset();
        test_cold_load();
        test_hit();
        test_store_merge();
        test_dirty_evict();
        test_reset_mid_fill();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
